// File: rtl/dff_bank_arbiter_pkg.sv
// Shared encodings for dff_bank_arbiter: FSM states and requester IDs.
package dff_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DRIVE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/dff_bank_arbiter_bank4.sv
// dff_bank4: 4-bit register with clock enable and asynchronous active-high reset to RESET_VALUE.
module dff_bank4 #(
  parameter logic [3:0] RESET_VALUE = 4'b0000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ce,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= RESET_VALUE;
    end else if (i_ce) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Two-requester arbiter for a shared 4-bit output bank with timed output enable.
// Define DFF_BANK_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise A has fixed priority.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int unsigned DRIVE_CYCLES = 3,
  parameter logic [3:0]  RESET_VALUE  = 4'b0000
) (
  input  logic       clk,
  input  logic       rstin,
  input  logic       req_a,
  input  logic [3:0] d_a,
  input  logic       req_b,
  input  logic [3:0] d_b,
  output logic [3:0] q,
  output logic       oe,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic       done,
  output state_t     dbg_state
);

  localparam logic [3:0] CNT_LOAD = 4'(DRIVE_CYCLES - 1);

  // Handshake: a requester raises req and holds it (with stable data while
  // granted) until done pulses; dropping req while granted cancels early.
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_oe;
  logic       r_gnt_a;
  logic       r_gnt_b;
  logic       r_busy;
  logic       r_done;
`ifdef DFF_BANK_ARBITER_ROUND_ROBIN_EN
  logic       r_last;
`endif

  logic       w_win_b;
  logic       w_req_own;
  logic       w_bank_ce;
  logic [3:0] w_bank_d;

  always_comb begin
    w_win_b = 1'b0;
`ifdef DFF_BANK_ARBITER_ROUND_ROBIN_EN
    w_win_b = req_b & (~req_a | (r_last == REQ_A));
`else
    w_win_b = req_b & ~req_a;
`endif
  end

  assign w_req_own = r_gnt_a ? req_a : req_b;
  assign w_bank_ce = (r_state == LOAD);
  assign w_bank_d  = r_gnt_b ? d_b : d_a;

  always_ff @(posedge clk or posedge rstin) begin
    if (rstin) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_oe    <= 1'b0;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef DFF_BANK_ARBITER_ROUND_ROBIN_EN
      r_last  <= REQ_B;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_a || req_b) begin
            r_gnt_a <= ~w_win_b;
            r_gnt_b <= w_win_b;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_cnt   <= CNT_LOAD;
          r_oe    <= 1'b1;
          r_state <= DRIVE;
        end
        DRIVE: begin
          if ((r_cnt == 4'd0) || !w_req_own) begin
            r_oe    <= 1'b0;
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_done  <= 1'b1;
            r_state <= RELEASE;
`ifdef DFF_BANK_ARBITER_ROUND_ROBIN_EN
            r_last  <= r_gnt_b ? REQ_B : REQ_A;
`endif
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RELEASE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dff_bank4 #(
    .RESET_VALUE(RESET_VALUE)
  ) u_bank (
    .i_clk(clk),
    .i_rst(rstin),
    .i_ce (w_bank_ce),
    .i_d  (w_bank_d),
    .o_q  (q)
  );

  assign oe        = r_oe;
  assign gnt_a     = r_gnt_a;
  assign gnt_b     = r_gnt_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule
